// File: rtl/lbus_pkg.sv
// Shared definitions for the local-bus master: FSM states, bus widths,
// default strobe timing and the slave register map.
package lbus_pkg;

  localparam int LBUS_ADDR_W = 12;
  localparam int LBUS_DATA_W = 16;

  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_STROBE_CYC = 8;
  localparam int DEF_HOLD_CYC   = 2;
  localparam int DEF_TURN_CYC   = 2;
  localparam int DEF_WAIT_TMO   = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_TURN
  } lbus_state_e;

  // Register map of the board's local-bus slaves
  localparam logic [LBUS_ADDR_W-1:0] REG_LED_CTRL     = 12'h000;
  localparam logic [LBUS_ADDR_W-1:0] REG_ID           = 12'h001;
  localparam logic [LBUS_ADDR_W-1:0] REG_STATUS_LO    = 12'h002;
  localparam logic [LBUS_ADDR_W-1:0] REG_STATUS_HI    = 12'h007;
  localparam logic [LBUS_ADDR_W-1:0] REG_GTX_LOOPBACK = 12'h010;
  localparam logic [LBUS_ADDR_W-1:0] REG_SCRATCH      = 12'hFFF;
  localparam logic [LBUS_DATA_W-1:0] ID_VALUE         = 16'h55AA;

  function automatic int lbus_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lbus_sync2.sv
// Two-flop synchroniser for the asynchronous slave wait line; resets to the
// inactive (high) level so a held reset never looks like a wait request.
module lbus_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;
  logic s1_d, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/lbus_master.sv
// Local-bus initiator: one command at a time becomes an async CPU-style cycle
// (cs_n/oe_n/we_n) with a single shared down-counter sequencing the phases.
module lbus_master
  import lbus_pkg::*;
#(
  parameter int ADDR_W     = LBUS_ADDR_W,
  parameter int DATA_W     = LBUS_DATA_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int TURN_CYC   = DEF_TURN_CYC,
  parameter int WAIT_TMO   = DEF_WAIT_TMO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] lbus_addr,
  inout  wire  [DATA_W-1:0] lbus_data,
  output logic              lbus_cs_n,
  output logic              lbus_oe_n,
  output logic              lbus_we_n,
  input  logic              lbus_wait_n
);

  localparam int CNT_MAX = lbus_max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, TURN_CYC);
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int TMO_W   = (WAIT_TMO < 1) ? 1 : $clog2(WAIT_TMO + 1);

  if (SETUP_CYC < 1)  begin : g_bad_setup  $error("lbus_master: SETUP_CYC must be >= 1");  end
  if (STROBE_CYC < 4) begin : g_bad_strobe $error("lbus_master: STROBE_CYC must be >= 4"); end
  if (HOLD_CYC < 1)   begin : g_bad_hold   $error("lbus_master: HOLD_CYC must be >= 1");   end
  if (TURN_CYC < 1)   begin : g_bad_turn   $error("lbus_master: TURN_CYC must be >= 1");   end
  if (WAIT_TMO < 0)   begin : g_bad_tmo    $error("lbus_master: WAIT_TMO must be >= 0");   end

  lbus_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              tmo_flag_q, tmo_flag_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              cs_n_q, cs_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              drive_q, drive_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              wait_sync;
  logic              cycle_active;

  lbus_sync2 u_wait_sync (
    .clk (clk),
    .rst (rst),
    .d   (lbus_wait_n),
    .q   (wait_sync)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    tmo_flag_d    = tmo_flag_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          we_d       = cmd_we;
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
          tmo_d      = '0;
          tmo_flag_d = 1'b0;
          cnt_d      = CNT_W'(SETUP_CYC - 1);
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(STROBE_CYC - 1);
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        // Minimum width first, then stretch while the slave holds wait_n low
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (wait_sync) begin
          rdata_d = we_q ? '0 : lbus_data;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
          state_d = ST_HOLD;
        end else if (tmo_q == TMO_W'(WAIT_TMO)) begin
          rdata_d    = '0;
          tmo_flag_d = 1'b1;
          cnt_d      = CNT_W'(HOLD_CYC - 1);
          state_d    = ST_HOLD;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = rdata_q;
          rsp_timeout_d = tmo_flag_q;
          cnt_d         = CNT_W'(TURN_CYC - 1);
          state_d       = ST_TURN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_TURN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus pins follow the next state so every strobe comes straight off a flop
    cycle_active = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    ready_d      = (state_d == ST_IDLE);
    cs_n_d       = ~cycle_active;
    oe_n_d       = ~((state_d == ST_STROBE) && !we_d);
    we_n_d       = ~((state_d == ST_STROBE) && we_d);
    drive_d      = cycle_active && we_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      tmo_q         <= '0;
      tmo_flag_q    <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      ready_q       <= 1'b0;
      cs_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      drive_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      tmo_flag_q    <= tmo_flag_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      ready_q       <= ready_d;
      cs_n_q        <= cs_n_d;
      oe_n_q        <= oe_n_d;
      we_n_q        <= we_n_d;
      drive_q       <= drive_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign busy        = ~ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign lbus_addr   = addr_q;
  assign lbus_cs_n   = cs_n_q;
  assign lbus_oe_n   = oe_n_q;
  assign lbus_we_n   = we_n_q;
  assign lbus_data   = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_lbus_master.sv
// Bench for lbus_master paired with a behavioural register-file slave; a
// weak pull-up on the data bus makes a released bus read back as all ones.
module tb_lbus_master;
  import lbus_pkg::*;

  localparam int SETUP_CYC  = 2;
  localparam int STROBE_CYC = 8;
  localparam int HOLD_CYC   = 2;
  localparam int TURN_CYC   = 2;
  localparam int WAIT_TMO   = 255;
  localparam int LAT        = 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC;
  localparam int GAP        = LAT + TURN_CYC;
  localparam int NV         = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_timeout;
  logic        busy;
  logic [11:0] lbus_addr;
  tri1  [15:0] lbus_data;
  logic        lbus_cs_n, lbus_oe_n, lbus_we_n;
  logic        lbus_wait_n = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  lbus_master #(
    .ADDR_W(12), .DATA_W(16), .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC(HOLD_CYC), .TURN_CYC(TURN_CYC), .WAIT_TMO(WAIT_TMO)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .busy(busy), .lbus_addr(lbus_addr), .lbus_data(lbus_data),
    .lbus_cs_n(lbus_cs_n), .lbus_oe_n(lbus_oe_n), .lbus_we_n(lbus_we_n), .lbus_wait_n(lbus_wait_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file slave: latches on the falling write strobe, drives while oe_n is low.
  // Scratch reads back inverted so a read cannot pass by echoing the last write.
  logic [15:0] led_ctrl = '0;
  logic [15:0] gtx_reg  = '0;
  logic [15:0] scratch  = '0;
  logic [15:0] slave_rd;

  always_comb begin
    slave_rd = 16'h0000;
    case (lbus_addr)
      REG_LED_CTRL:     slave_rd = led_ctrl;
      REG_ID:           slave_rd = ID_VALUE;
      REG_GTX_LOOPBACK: slave_rd = gtx_reg;
      REG_SCRATCH:      slave_rd = ~scratch;
      default:
        if (lbus_addr >= REG_STATUS_LO && lbus_addr <= REG_STATUS_HI)
          slave_rd = 16'h5000 | {4'h0, lbus_addr};
    endcase
  end

  assign lbus_data = (!lbus_cs_n && !lbus_oe_n) ? slave_rd : 16'hzzzz;

  always @(negedge lbus_we_n) begin
    if (!rst && !lbus_cs_n) begin
      case (lbus_addr)
        REG_LED_CTRL:     led_ctrl <= lbus_data;
        REG_GTX_LOOPBACK: gtx_reg  <= lbus_data;
        REG_SCRATCH:      scratch  <= lbus_data;
        default: ;
      endcase
    end
  end

  // Strobe widths and bus-protocol violations
  int   rd_w = 0, wr_w = 0, last_rd_w = 0, last_wr_w = 0, viol = 0;
  logic rd_busy = 1'b0;

  always @(negedge clk) begin
    if (!lbus_oe_n) rd_w <= rd_w + 1;
    else if (rd_w != 0) begin last_rd_w <= rd_w; rd_w <= 0; end
    if (!lbus_we_n) wr_w <= wr_w + 1;
    else if (wr_w != 0) begin last_wr_w <= wr_w; wr_w <= 0; end
    viol <= viol + int'(!lbus_oe_n && !lbus_we_n)
                 + int'(!rst && lbus_cs_n && lbus_data !== 16'hFFFF)
                 + int'(!rst && rd_busy && lbus_oe_n && lbus_data !== 16'hFFFF);
  end

  typedef struct {
    logic [11:0] addr;
    logic        we;
    logic [15:0] rdata;
    logic        tmo;
    int          lat;
    int          strobe;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] rdata;
    logic        tmo;
    int          cyc;
    int          rd_w;
    int          wr_w;
  } obs_t;

  exp_t sb[$];
  obs_t obs[$];

  always @(posedge clk) begin
    #1;
    if (rsp_valid)
      obs.push_back('{rdata: rsp_rdata, tmo: rsp_timeout, cyc: cyc, rd_w: last_rd_w, wr_w: last_wr_w});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [11:0] a, input logic [15:0] wd,
                       input logic [15:0] exp_rd, input logic exp_tmo, input int exp_lat,
                       input int exp_strb, output int acc);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = wd;
    @(negedge clk);
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: cmd_ready low for %0d cycles, required high", n);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    rd_busy = !we;
    sb.push_back('{addr: a, we: we, rdata: exp_rd, tmo: exp_tmo, lat: exp_lat, strobe: exp_strb, acc: acc});
  endtask

  task automatic collect(input int limit);
    exp_t e;
    obs_t o;
    int   n;
    while (sb.size() != 0) begin
      n = 0;
      while (obs.size() == 0 && n < limit) begin
        @(negedge clk);
        n++;
      end
      if (obs.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_wait: no rsp_valid within %0d cycles, %0d responses outstanding", limit, sb.size());
        sb.delete();
        return;
      end
      e = sb.pop_front();
      o = obs.pop_front();
      check($sformatf("rdata@%03h", e.addr), 32'(o.rdata), 32'(e.rdata));
      check($sformatf("timeout@%03h", e.addr), 32'(o.tmo), 32'(e.tmo));
      check($sformatf("latency@%03h", e.addr), 32'(o.cyc - e.acc + 1), 32'(e.lat));
      check($sformatf("strobe_w@%03h", e.addr), 32'(e.we ? o.wr_w : o.rd_w), 32'(e.strobe));
    end
  endtask

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[NV];
  int   acc_t[NV];
  int   acc;

  initial begin
    vt[0] = '{1'b1, REG_LED_CTRL,     16'h1234, 16'h0000};
    vt[1] = '{1'b0, REG_ID,           16'h0BAD, 16'h55AA};
    vt[2] = '{1'b1, REG_SCRATCH,      16'h00FF, 16'h0000};
    vt[3] = '{1'b0, REG_SCRATCH,      16'h0BAD, 16'hFF00};
    vt[4] = '{1'b0, REG_LED_CTRL,     16'h0BAD, 16'h1234};
    vt[5] = '{1'b1, REG_GTX_LOOPBACK, 16'hBEEF, 16'h0000};
    vt[6] = '{1'b0, REG_GTX_LOOPBACK, 16'h0BAD, 16'hBEEF};
    vt[7] = '{1'b0, 12'h005,          16'h0BAD, 16'h5005};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_cs_n", 32'(lbus_cs_n), 32'd1);
    check("rst_oe_n", 32'(lbus_oe_n), 32'd1);
    check("rst_we_n", 32'(lbus_we_n), 32'd1);
    check("rst_addr", 32'(lbus_addr), 32'd0);
    check("rst_data_released", 32'(lbus_data), 32'hFFFF);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(cmd_ready), 32'd1);
    check("busy_after_rst", 32'(busy), 32'd0);

    // Back-to-back table; cmd_valid stays high through each busy period
    for (int i = 0; i < NV; i++) begin
      issue(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp, 1'b0, LAT, STROBE_CYC, acc_t[i]);
      if (i == 0) check("busy_in_cycle", 32'(busy), 32'd1);
      if (i > 0) check($sformatf("accept_gap_%0d", i), 32'(acc_t[i] - acc_t[i-1]), 32'(GAP));
    end
    cmd_valid = 1'b0;
    collect(100);
    check("slave_led_ctrl", 32'(led_ctrl), 32'h1234);
    check("slave_gtx", 32'(gtx_reg), 32'hBEEF);

    // wait_n held low for 20 cycles from the start of the read strobe
    issue(1'b0, REG_ID, 16'h0BAD, 16'h55AA, 1'b0, LAT + 15, STROBE_CYC + 15, acc);
    cmd_valid = 1'b0;
    for (int n = 0; n < 50 && lbus_oe_n; n++) @(negedge clk);
    lbus_wait_n = 1'b0;
    repeat (20) @(negedge clk);
    lbus_wait_n = 1'b1;
    collect(100);

    // wait_n stuck low: abort after STROBE_CYC + WAIT_TMO strobe cycles
    @(negedge clk);
    lbus_wait_n = 1'b0;
    issue(1'b0, REG_ID, 16'h0BAD, 16'h0000, 1'b1, LAT + WAIT_TMO, STROBE_CYC + WAIT_TMO, acc);
    cmd_valid = 1'b0;
    collect(400);
    check("tmo_cs_n_idle", 32'(lbus_cs_n), 32'd1);
    check("tmo_oe_n_idle", 32'(lbus_oe_n), 32'd1);
    check("tmo_data_released", 32'(lbus_data), 32'hFFFF);
    lbus_wait_n = 1'b1;
    issue(1'b0, 12'h002, 16'h0BAD, 16'h5002, 1'b0, LAT, STROBE_CYC, acc);
    cmd_valid = 1'b0;
    collect(100);

    // Asynchronous reset in the middle of a write strobe
    issue(1'b1, REG_SCRATCH, 16'hA5A5, 16'h0000, 1'b0, LAT, STROBE_CYC, acc);
    cmd_valid = 1'b0;
    for (int n = 0; n < 50 && lbus_we_n; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("pre_rst_we_n_low", 32'(lbus_we_n), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_cs_n", 32'(lbus_cs_n), 32'd1);
    check("midrst_we_n", 32'(lbus_we_n), 32'd1);
    check("midrst_oe_n", 32'(lbus_oe_n), 32'd1);
    check("midrst_data_released", 32'(lbus_data), 32'hFFFF);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("midrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    sb.delete();
    rd_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_midrst", 32'(cmd_ready), 32'd1);
    issue(1'b0, REG_ID, 16'h0BAD, 16'h55AA, 1'b0, LAT, STROBE_CYC, acc);
    cmd_valid = 1'b0;
    collect(100);

    repeat (20) @(negedge clk);
    check("no_extra_rsp", 32'(obs.size()), 32'd0);
    check("bus_protocol_viol", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
